program_loader: RTL and testbench
=================================

# program_loader

Boot-time program loader that sits upstream of the 16-bit CPU. It accepts a byte stream over a valid/ready handshake and packs it into 16-bit instruction words. Each word is written sequentially into the CPU's 256-word RAM through the RAM write port. The CPU core is held in reset until a complete, checksum-verified image has been stored.

## Interface
Parameters:
- ADR_W, 8, RAM word-address width (256 words)
- DATA_W, 16, RAM word width; fixed at two bytes per word
- START_ADR, 8'h00, first RAM address written

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high; one clock, synchronous reset, polarity and synchronicity fixed
- in_valid  input  1  byte available on in_data
- in_data  input  8  stream byte
- in_ready  output  1  loader can accept a byte this cycle
- ram_we  output  1  one-cycle RAM write strobe
- ram_adr  output  ADR_W  RAM write address
- ram_wdata  output  DATA_W  RAM write data
- cpu_reset  output  1  drives the CPU core reset; high until the load succeeds
- done  output  1  image loaded and verified, CPU running
- error  output  1  checksum mismatch, sticky until reset

## Operation
- Stream format: COUNT byte N, then N words of two bytes each (high byte first), then one CHK byte.
  - N=0 means 256 words.
  - CHK = XOR of all 2N data bytes; the COUNT byte is excluded from CHK.
- A byte transfers on a cycle where in_valid && in_ready.
- States:
  - S_COUNT: wait for the COUNT byte. On transfer, latch remaining=(N==0)?256:N (9-bit counter), clear chk, set adr=START_ADR, go to S_HI.
  - S_HI: on transfer, latch the high byte, chk^=byte, go to S_LO.
  - S_LO: on transfer, chk^=byte and register {hi, byte} to ram_wdata, adr to ram_adr, assert ram_we next cycle. Then adr+=1 (wraps modulo 256) and remaining-=1. Go to S_CHK if remaining becomes 0, else S_HI.
  - S_CHK: on transfer, go to S_RUN if byte==chk, else S_ERR.
  - S_RUN: in_ready=0, cpu_reset=0, done=1. Terminal until reset.
  - S_ERR: in_ready=0, cpu_reset=1, error=1. Terminal until reset.
- in_ready=1 in S_COUNT, S_HI, S_LO and S_CHK.
  - in_ready is registered-state decoded only, never combinationally dependent on in_valid.
- Idle cycles (in_valid=0) between any two bytes are allowed and change no state.
- A count wrap past 8'hFF returns to 8'h00. With START_ADR≠0 and N=256, the last word lands at START_ADR-1.
- Reset mid-load returns to S_COUNT with all outputs at reset values. Words already written stay in RAM and are overwritten by the next load.

## Timing
- Reset values: in_ready=1 (S_COUNT), ram_we=0, ram_adr=START_ADR, ram_wdata=0, cpu_reset=1, done=0, error=0.
- ram_we is high exactly one cycle, the cycle after the LO-byte transfer. ram_adr and ram_wdata are stable during that cycle.
- At most one write every 2 cycles (back-to-back bytes give a write every second cycle).
- cpu_reset falls, and done rises, the cycle after the CHK transfer when CHK matches.
- error rises the cycle after a mismatching CHK transfer.
- Minimum load time for N words: 2N+2 transfer cycles, plus 1 cycle until cpu_reset falls.
- If reset and a transfer occur in the same cycle, reset wins and the byte is discarded.

## Structure
- Shared cpu package:
  - loader state enum (S_COUNT, S_HI, S_LO, S_CHK, S_RUN, S_ERR)
  - ADR_W/DATA_W constants, shared with RAM and Program_counter
- Single module, no sub-module. The FSM, 9-bit remaining counter, address counter and XOR accumulator live in one always block plus output decode.
- Top-level integration:
  - the CPU top gains a loader instance
  - RAM gains a write port (we/adr/wdata)
  - the core reset becomes reset || cpu_reset

## Test plan
- Basic load: send 02,12,34,AB,CD,XOR=40. Required: writes 0x00←1234 and 0x01←ABCD, done=1 and cpu_reset=0 one cycle after the CHK byte.
- Bad checksum: same stream with CHK=41. Required: both writes occur, error=1, cpu_reset stays 1, in_ready=0 thereafter, further bytes are ignored.
- Stalls: insert random 0-5 cycle in_valid gaps into the basic load. Required: identical writes and final state, ram_we only on LO transfers.
- Full image and wrap: COUNT=00 with START_ADR=8'h10, 256 words of value = index. Required: 256 writes, the last at adr 0x0F, done=1.
- Reset mid-load: assert reset after the second data byte of the basic load, then resend the full stream. Required: outputs at reset values the cycle after reset, followed by a normal successful load.
- Reset collision: assert reset on the same cycle as the CHK transfer. Required: done stays 0 and the loader is back in S_COUNT.

Source files
------------

// File: rtl/program_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : program_loader_pkg
// Brief    : Shared CPU constants and the boot loader state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package program_loader_pkg;

  localparam int C_ADR_W  = 8;   // RAM word-address width (256 words)
  localparam int C_DATA_W = 16;  // RAM word width, two stream bytes
  localparam int C_CNT_W  = 9;   // remaining-word counter, holds 1..256

  typedef enum logic [2:0] {
    S_COUNT = 3'd0,
    S_HI    = 3'd1,
    S_LO    = 3'd2,
    S_CHK   = 3'd3,
    S_RUN   = 3'd4,
    S_ERR   = 3'd5
  } loader_state_t;

endpackage
`default_nettype wire

// File: rtl/program_loader_if.sv
`default_nettype none
// ============================================================================
// Module   : program_loader_if
// Brief    : Byte-stream handshake, RAM write port and CPU control bundle.
//            slave  = the loader, master = the system around it.
// Revision : 1.0 - initial release
// ============================================================================
interface program_loader_if
  import program_loader_pkg::*;
#(
  parameter int ADR_W  = C_ADR_W,
  parameter int DATA_W = C_DATA_W
);

  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              ram_we;
  logic [ADR_W-1:0]  ram_adr;
  logic [DATA_W-1:0] ram_wdata;
  logic              cpu_reset;
  logic              done;
  logic              error;

  modport slave (
    input  in_valid, in_data,
    output in_ready, ram_we, ram_adr, ram_wdata, cpu_reset, done, error
  );

  modport master (
    output in_valid, in_data,
    input  in_ready, ram_we, ram_adr, ram_wdata, cpu_reset, done, error
  );

endinterface
`default_nettype wire

// File: rtl/program_loader.sv
`default_nettype none
// ============================================================================
// Module   : program_loader
// Brief    : Packs a COUNT/data/CHK byte stream into 16-bit words, writes
//            them to CPU RAM and releases the CPU once the XOR checksum
//            of the data bytes matches.
// Revision : 1.0 - initial release
// ============================================================================
module program_loader
  import program_loader_pkg::*;
#(
  parameter int               ADR_W     = C_ADR_W,
  parameter int               DATA_W    = C_DATA_W,
  parameter logic [ADR_W-1:0] START_ADR = '0
)(
  input wire               clk,
  input wire               reset,
  program_loader_if.slave  bus
);

  loader_state_t        r_state;
  loader_state_t        w_next;
  logic [C_CNT_W-1:0]   r_remaining;
  logic [ADR_W-1:0]     r_adr;
  logic [7:0]           r_chk;
  logic [7:0]           r_hi;
  logic                 r_ram_we;
  logic [ADR_W-1:0]     r_ram_adr;
  logic [DATA_W-1:0]    r_ram_wdata;

  logic                 w_in_ready;
  logic                 w_cpu_reset;
  logic                 w_done;
  logic                 w_error;
  logic                 w_xfer;

  // in_ready comes from the registered state only, so the handshake has
  // no combinational path from in_valid back to in_ready.
  assign w_xfer = bus.in_valid && w_in_ready;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_COUNT;
    end else begin
      r_state <= w_next;
    end
  end

  // Datapath: word counter, address counter, checksum and RAM write port
  always_ff @(posedge clk) begin
    if (reset) begin
      r_remaining <= '0;
      r_adr       <= START_ADR;
      r_chk       <= '0;
      r_hi        <= '0;
      r_ram_we    <= 1'b0;
      r_ram_adr   <= START_ADR;
      r_ram_wdata <= '0;
    end else begin
      r_ram_we <= 1'b0;
      if (w_xfer) begin
        case (r_state)
          S_COUNT: begin
            // A COUNT of zero encodes a full 256-word image.
            r_remaining <= (bus.in_data == 8'd0) ? C_CNT_W'(256)
                                                 : {1'b0, bus.in_data};
            r_chk       <= '0;
            r_adr       <= START_ADR;
          end
          S_HI: begin
            r_hi  <= bus.in_data;
            r_chk <= r_chk ^ bus.in_data;
          end
          S_LO: begin
            r_chk       <= r_chk ^ bus.in_data;
            r_ram_we    <= 1'b1;
            r_ram_adr   <= r_adr;
            r_ram_wdata <= DATA_W'({r_hi, bus.in_data});
            // Address wraps naturally at the top of RAM.
            r_adr       <= r_adr + ADR_W'(1);
            r_remaining <= r_remaining - C_CNT_W'(1);
          end
          default: ;
        endcase
      end
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_COUNT: if (w_xfer) w_next = S_HI;
      S_HI:    if (w_xfer) w_next = S_LO;
      S_LO:    if (w_xfer) w_next = (r_remaining == C_CNT_W'(1)) ? S_CHK : S_HI;
      S_CHK:   if (w_xfer) w_next = (bus.in_data == r_chk) ? S_RUN : S_ERR;
      S_RUN:   w_next = S_RUN;
      S_ERR:   w_next = S_ERR;
      default: w_next = S_COUNT;
    endcase
  end

  // Output decode from the registered state
  always_comb begin
    w_in_ready  = 1'b0;
    w_cpu_reset = 1'b1;
    w_done      = 1'b0;
    w_error     = 1'b0;
    case (r_state)
      S_COUNT, S_HI, S_LO, S_CHK: w_in_ready = 1'b1;
      S_RUN: begin
        w_cpu_reset = 1'b0;
        w_done      = 1'b1;
      end
      S_ERR:   w_error = 1'b1;
      default: ;
    endcase
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.ram_we    = r_ram_we;
  assign bus.ram_adr   = r_ram_adr;
  assign bus.ram_wdata = r_ram_wdata;
  assign bus.cpu_reset = w_cpu_reset;
  assign bus.done      = w_done;
  assign bus.error     = w_error;

endmodule
`default_nettype wire

// File: tb/tb_program_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_program_loader
// Brief    : Self-checking bench for program_loader. Two instances (start
//            address 0x00 and 0x10) receive the same byte stream; a stream
//            model predicts every RAM write and the final status.
// Revision : 1.0 - initial release
// ============================================================================
module tb_program_loader;

  logic       clk      = 1'b0;
  logic       reset    = 1'b1;
  logic       tb_valid = 1'b0;
  logic [7:0] tb_data  = 8'h00;

  always #5 clk = ~clk;

  program_loader_if bus0();
  program_loader_if bus1();

  assign bus0.in_valid = tb_valid;
  assign bus0.in_data  = tb_data;
  assign bus1.in_valid = tb_valid;
  assign bus1.in_data  = tb_data;

  program_loader #(.START_ADR(8'h00)) u_dut0 (.clk(clk), .reset(reset), .bus(bus0.slave));
  program_loader #(.START_ADR(8'h10)) u_dut1 (.clk(clk), .reset(reset), .bus(bus1.slave));

  int n_checks = 0;
  int n_errors = 0;

  logic [23:0] q0[$];
  logic [23:0] q1[$];
  int          wr0 = 0;
  int          wr1 = 0;
  logic        prev_we0 = 1'b0;
  logic        prev_we1 = 1'b0;
  logic [7:0]  last_adr0 = 8'h00;
  logic [7:0]  last_adr1 = 8'h00;
  logic [7:0]  stream[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Write monitor: every write must be predicted, in order, and spaced.
  always @(negedge clk) begin
    if (bus0.ram_we === 1'b1) begin
      check_eq("wr0_spacing", prev_we0, 0);
      check_eq("wr0_predicted", q0.size() != 0, 1);
      if (q0.size() != 0) check_eq("wr0_word", {bus0.ram_adr, bus0.ram_wdata}, q0.pop_front());
      last_adr0 = bus0.ram_adr;
      wr0++;
    end
    if (bus1.ram_we === 1'b1) begin
      check_eq("wr1_spacing", prev_we1, 0);
      check_eq("wr1_predicted", q1.size() != 0, 1);
      if (q1.size() != 0) check_eq("wr1_word", {bus1.ram_adr, bus1.ram_wdata}, q1.pop_front());
      last_adr1 = bus1.ram_adr;
      wr1++;
    end
    prev_we0 = bus0.ram_we;
    prev_we1 = bus1.ram_we;
  end

  // ---- stream model ----
  function automatic int stream_words();
    return (stream[0] == 8'd0) ? 256 : int'(stream[0]);
  endfunction

  function automatic logic [7:0] stream_xor();
    logic [7:0] x = 8'h00;
    for (int i = 1; i <= 2 * stream_words(); i++) x ^= stream[i];
    return x;
  endfunction

  // Queue the writes for every word whose LO byte lies within the first
  // 'sent' bytes of the stream.
  task automatic expect_writes(input int sent);
    for (int k = 0; k < stream_words(); k++) begin
      if (2 + 2 * k < sent) begin
        q0.push_back({8'(8'h00 + k), stream[1 + 2 * k], stream[2 + 2 * k]});
        q1.push_back({8'(8'h10 + k), stream[1 + 2 * k], stream[2 + 2 * k]});
      end
    end
  endtask

  task automatic build_basic(input logic [7:0] chk);
    stream.delete();
    stream.push_back(8'h02);
    stream.push_back(8'h12); stream.push_back(8'h34);
    stream.push_back(8'hAB); stream.push_back(8'hCD);
    stream.push_back(chk);
  endtask

  task automatic build_random();
    int         n;
    logic [7:0] c;
    stream.delete();
    n = int'($urandom_range(1, 8));
    stream.push_back(8'(n));
    for (int i = 0; i < 2 * n; i++) stream.push_back(8'($urandom));
    c = stream_xor();
    if ($urandom_range(0, 3) == 0) c ^= 8'(1 << $urandom_range(0, 7));
    stream.push_back(c);
  endtask

  // ---- drivers (called at posedge+1) ----
  task automatic send_byte(input logic [7:0] b, input int maxgap);
    int gap;
    gap = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
    tb_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    tb_valid = 1'b1;
    tb_data  = b;
    check_eq("rdy0_at_xfer", bus0.in_ready, 1);
    check_eq("rdy1_at_xfer", bus1.in_ready, 1);
    @(posedge clk); #1;
    tb_valid = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_rdy0"},   bus0.in_ready, 1);
    check_eq({tag, "_we0"},    bus0.ram_we, 0);
    check_eq({tag, "_adr0"},   bus0.ram_adr, 8'h00);
    check_eq({tag, "_wd0"},    bus0.ram_wdata, 0);
    check_eq({tag, "_crst0"},  bus0.cpu_reset, 1);
    check_eq({tag, "_done0"},  bus0.done, 0);
    check_eq({tag, "_err0"},   bus0.error, 0);
    check_eq({tag, "_adr1"},   bus1.ram_adr, 8'h10);
    check_eq({tag, "_crst1"},  bus1.cpu_reset, 1);
    check_eq({tag, "_done1"},  bus1.done, 0);
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    @(posedge clk); #1;
    check_reset_vals(tag);
    reset = 1'b0;
  endtask

  // Send the whole stream and check the outcome the model predicts.
  task automatic run_load(input string tag, input int maxgap);
    int   n, s0, s1;
    logic ok;
    n  = stream_words();
    ok = (stream[2 * n + 1] == stream_xor());
    s0 = wr0;
    s1 = wr1;
    expect_writes(stream.size());
    for (int i = 0; i < stream.size() - 1; i++) send_byte(stream[i], maxgap);
    check_eq({tag, "_done_early"}, bus0.done, 0);
    check_eq({tag, "_crst_early"}, bus0.cpu_reset, 1);
    send_byte(stream[stream.size() - 1], maxgap);
    check_eq({tag, "_done0"}, bus0.done, ok);
    check_eq({tag, "_err0"},  bus0.error, !ok);
    check_eq({tag, "_crst0"}, bus0.cpu_reset, !ok);
    check_eq({tag, "_rdy0"},  bus0.in_ready, 0);
    check_eq({tag, "_done1"}, bus1.done, ok);
    check_eq({tag, "_err1"},  bus1.error, !ok);
    @(negedge clk);
    check_eq({tag, "_wrcnt0"}, wr0 - s0, n);
    check_eq({tag, "_wrcnt1"}, wr1 - s1, n);
    check_eq({tag, "_q0_left"}, q0.size(), 0);
    check_eq({tag, "_q1_left"}, q1.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    int s0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("por");
    reset = 1'b0;

    // Basic load, back-to-back bytes
    build_basic(8'h40);
    run_load("basic", 0);
    check_eq("basic_lastadr0", last_adr0, 8'h01);
    do_reset("rst_a");

    // Bad checksum, then bytes offered while in the error state
    build_basic(8'h41);
    run_load("badchk", 0);
    s0 = wr0;
    for (int i = 0; i < 6; i++) begin
      tb_valid = 1'b1;
      tb_data  = 8'($urandom);
      @(posedge clk); #1;
    end
    tb_valid = 1'b0;
    @(negedge clk);
    check_eq("err_ignored_wr", wr0 - s0, 0);
    check_eq("err_sticky", bus0.error, 1);
    check_eq("err_rdy", bus0.in_ready, 0);
    check_eq("err_crst", bus0.cpu_reset, 1);
    @(posedge clk); #1;
    do_reset("rst_b");

    // Stalls between bytes
    build_basic(8'h40);
    run_load("stall", 5);
    do_reset("rst_c");

    // Full 256-word image with address wrap
    stream.delete();
    stream.push_back(8'h00);
    for (int k = 0; k < 256; k++) begin
      stream.push_back(8'h00);
      stream.push_back(8'(k));
    end
    stream.push_back(stream_xor());
    run_load("full", 0);
    check_eq("full_lastadr0", last_adr0, 8'hFF);
    check_eq("full_lastadr1", last_adr1, 8'h0F);
    do_reset("rst_d");

    // Reset after the second data byte, then a clean reload
    build_basic(8'h40);
    expect_writes(3);
    for (int i = 0; i < 3; i++) send_byte(stream[i], 0);
    do_reset("midload");
    run_load("reload", 0);
    do_reset("rst_e");

    // Reset on the same cycle as the CHK transfer
    build_basic(8'h40);
    expect_writes(5);
    for (int i = 0; i < 5; i++) send_byte(stream[i], 0);
    tb_valid = 1'b1;
    tb_data  = 8'h40;
    reset    = 1'b1;
    @(posedge clk); #1;
    tb_valid = 1'b0;
    reset    = 1'b0;
    check_eq("coll_done", bus0.done, 0);
    check_eq("coll_rdy", bus0.in_ready, 1);
    check_eq("coll_crst", bus0.cpu_reset, 1);
    check_eq("coll_err", bus0.error, 0);
    run_load("after_coll", 0);

    // Randomized loads
    for (int it = 0; it < 12; it++) begin
      do_reset("rst_r");
      build_random();
      run_load("rand", int'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
